io_port_ctrl: RTL and testbench

- Peripheral-side counterpart of the processor core's I/O interface: produces the core's `data_in` and `interrupt`, and consumes the core's `data_out`.
- Inbound bytes from an external device are buffered in a small FIFO. The FIFO head is presented to the core on `data_in`, and a one-cycle interrupt is raised when buffered data reaches a threshold.
- Outbound bytes written by the core are held in a single-entry register and delivered to the external device over a valid/ready handshake.

---
 rtl/io_port_ctrl.sv | 175 +++++++++++++++++
 tb/tb_io_port_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_ctrl.sv
// io_port_ctrl
//   Peripheral-side I/O block for the processor core. Inbound bytes from an
//   external device are buffered in a small FIFO whose head drives the core's
//   data_in; a one-cycle interrupt pulse is raised when occupancy reaches
//   INT_THRESH. Outbound bytes written by the core are held in a single-entry
//   register and handed to the external device over valid/ready.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_ARMED | waiting for int_en && fifo_count >= INT_THRESH
//   S_FIRE  | interrupt pulse high for exactly this cycle
//   S_WAIT  | pulse delivered; re-arms only once the FIFO drains to empty
//
// Ports
//   clk, reset                   system clock, synchronous active-high reset
//   ext_in_data/valid/ready      inbound byte stream into the FIFO
//   data_in                      FIFO head to core (8'h00 when empty)
//   cpu_rd                       core read strobe, pops FIFO head
//   data_out, cpu_wr             core write data and write strobe
//   ext_out_data/valid/ready     outbound byte handshake to external device
//   int_en, interrupt            interrupt enable and one-cycle pulse
//   fifo_count                   current FIFO occupancy
//   io_err                       sticky error (read on empty, dropped write)

module io_port_ctrl #(
    parameter int DEPTH      = 4,
    parameter int INT_THRESH = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               ext_in_data,
    input  logic                     ext_in_valid,
    output logic                     ext_in_ready,
    output logic [7:0]               data_in,
    input  logic                     cpu_rd,
    input  logic [7:0]               data_out,
    input  logic                     cpu_wr,
    output logic [7:0]               ext_out_data,
    output logic                     ext_out_valid,
    input  logic                     ext_out_ready,
    input  logic                     int_en,
    output logic                     interrupt,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     io_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_ARMED = 2'd0,
        S_FIRE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_out_data;
    logic          r_out_valid;
    logic          r_io_err;
    logic          r_interrupt;
    state_t        r_state;
    state_t        w_state_nxt;

    logic w_empty;
    logic w_full;
    logic w_push;
    logic w_pop;
    logic w_rd_err;
    logic w_wr_accept;
    logic w_wr_err;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CW'(DEPTH));
    assign w_push  = ext_in_valid && !w_full;
    assign w_pop   = cpu_rd && !w_empty;
    assign w_rd_err = cpu_rd && w_empty;

    // A write is accepted when the holding register is free or being
    // drained on this same edge; otherwise it is lost and flagged.
    assign w_wr_accept = cpu_wr && (!r_out_valid || ext_out_ready);
    assign w_wr_err    = cpu_wr && r_out_valid && !ext_out_ready;

    // FIFO storage is not reset; pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ext_in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_wr_accept) begin
            r_out_data  <= data_out;
            r_out_valid <= 1'b1;
        end else if (r_out_valid && ext_out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_io_err <= 1'b0;
        end else if (w_rd_err || w_wr_err) begin
            r_io_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_ARMED;
            r_interrupt <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_interrupt <= (w_state_nxt == S_FIRE);
        end
    end

    // Threshold is judged on registered occupancy, so a push that reaches
    // the threshold is seen one edge later.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_ARMED: begin
                if (int_en && (r_count >= CW'(INT_THRESH))) begin
                    w_state_nxt = S_FIRE;
                end
            end
            S_FIRE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_empty) begin
                    w_state_nxt = S_ARMED;
                end
            end
            default: begin
                w_state_nxt = S_ARMED;
            end
        endcase
    end

    assign ext_in_ready  = !w_full;
    assign data_in       = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    assign ext_out_data  = r_out_data;
    assign ext_out_valid = r_out_valid;
    assign interrupt     = r_interrupt;
    assign fifo_count    = r_count;
    assign io_err        = r_io_err;

endmodule

// File: tb/tb_io_port_ctrl.sv
module tb_io_port_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] ext_in_data;
    logic       ext_in_valid;
    logic       ext_in_ready;
    logic [7:0] data_in;
    logic       cpu_rd;
    logic [7:0] data_out;
    logic       cpu_wr;
    logic [7:0] ext_out_data;
    logic       ext_out_valid;
    logic       ext_out_ready;
    logic       int_en;
    logic       interrupt;
    logic [2:0] fifo_count;
    logic       io_err;

    int n_checks = 0;
    int n_errors = 0;

    io_port_ctrl #(.DEPTH(4), .INT_THRESH(1)) dut (
        .clk           (clk),
        .reset         (reset),
        .ext_in_data   (ext_in_data),
        .ext_in_valid  (ext_in_valid),
        .ext_in_ready  (ext_in_ready),
        .data_in       (data_in),
        .cpu_rd        (cpu_rd),
        .data_out      (data_out),
        .cpu_wr        (cpu_wr),
        .ext_out_data  (ext_out_data),
        .ext_out_valid (ext_out_valid),
        .ext_out_ready (ext_out_ready),
        .int_en        (int_en),
        .interrupt     (interrupt),
        .fifo_count    (fifo_count),
        .io_err        (io_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one rising edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; ext_in_data = 8'h00; ext_in_valid = 1'b0; cpu_rd = 1'b0;
        data_out = 8'h00; cpu_wr = 1'b0; ext_out_ready = 1'b0; int_en = 1'b0;
        step();
        step();
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", ext_in_ready, 1);
        chk("rst_out_valid", ext_out_valid, 0);
        chk("rst_out_data", ext_out_data, 8'h00);
        chk("rst_interrupt", interrupt, 0);
        chk("rst_io_err", io_err, 0);
        chk("rst_data_in", data_in, 8'h00);
        reset = 1'b0;

        // 1: single push with threshold 1
        int_en = 1'b1;
        ext_in_data = 8'hA5; ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        chk("t1_data_in", data_in, 8'hA5);
        chk("t1_count", fifo_count, 1);
        chk("t1_int_n0", interrupt, 0);
        step();
        chk("t1_int_n1", interrupt, 1);
        step();
        chk("t1_int_n2", interrupt, 0);
        step();
        chk("t1_int_n3", interrupt, 0);
        int_en = 1'b0;
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        chk("t1_pop_count", fifo_count, 0);
        chk("t1_pop_data", data_in, 8'h00);
        step();

        // 2: fill to full, held 5th byte, pops
        for (int i = 1; i <= 4; i++) begin
            ext_in_data = 8'(i); ext_in_valid = 1'b1;
            step();
        end
        chk("t2_full_ready", ext_in_ready, 0);
        chk("t2_full_count", fifo_count, 4);
        chk("t2_head", data_in, 8'h01);
        ext_in_data = 8'h05; ext_in_valid = 1'b1;
        step();
        chk("t2_no_ovf_count", fifo_count, 4);
        chk("t2_no_ovf_head", data_in, 8'h01);
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        chk("t2_pop1_data", data_in, 8'h02);
        chk("t2_pop1_count", fifo_count, 3);
        chk("t2_pop1_ready", ext_in_ready, 1);
        step();
        ext_in_valid = 1'b0;
        chk("t2_push5_count", fifo_count, 4);
        chk("t2_push5_ready", ext_in_ready, 0);
        cpu_rd = 1'b1;
        step();
        chk("t2_pop2", data_in, 8'h03);
        step();
        chk("t2_pop3", data_in, 8'h04);
        step();
        chk("t2_pop4", data_in, 8'h05);
        step();
        cpu_rd = 1'b0;
        chk("t2_pop5", data_in, 8'h00);
        chk("t2_empty_count", fifo_count, 0);
        chk("t2_no_err", io_err, 0);

        // 3: simultaneous push and pop at count 2
        ext_in_valid = 1'b1;
        ext_in_data = 8'h10; step();
        ext_in_data = 8'h20; step();
        chk("t3_count2", fifo_count, 2);
        ext_in_data = 8'h77; cpu_rd = 1'b1;
        step();
        ext_in_valid = 1'b0;
        chk("t3_pp_count", fifo_count, 2);
        chk("t3_pp_head", data_in, 8'h20);
        step();
        chk("t3_head77", data_in, 8'h77);
        chk("t3_count1", fifo_count, 1);
        step();
        cpu_rd = 1'b0;
        chk("t3_empty", data_in, 8'h00);
        chk("t3_no_err", io_err, 0);

        // 4: read on empty
        cpu_rd = 1'b1;
        step();
        cpu_rd = 1'b0;
        chk("t4_err", io_err, 1);
        chk("t4_count", fifo_count, 0);
        step(); step(); step();
        chk("t4_sticky", io_err, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t4_rst_err", io_err, 0);

        // 5: outbound register
        data_out = 8'h3C; cpu_wr = 1'b1; ext_out_ready = 1'b0;
        step();
        chk("t5_valid", ext_out_valid, 1);
        chk("t5_data", ext_out_data, 8'h3C);
        chk("t5_no_err", io_err, 0);
        data_out = 8'hC3;
        step();
        chk("t5_drop_data", ext_out_data, 8'h3C);
        chk("t5_drop_err", io_err, 1);
        chk("t5_drop_valid", ext_out_valid, 1);
        data_out = 8'h99; ext_out_ready = 1'b1;
        step();
        chk("t5_b2b_data", ext_out_data, 8'h99);
        chk("t5_b2b_valid", ext_out_valid, 1);
        cpu_wr = 1'b0;
        step();
        ext_out_ready = 1'b0;
        chk("t5_drain_valid", ext_out_valid, 0);
        chk("t5_drain_data", ext_out_data, 8'h99);

        // 6: interrupt enable gating and re-arm
        reset = 1'b1;
        step();
        reset = 1'b0;
        int_en = 1'b0;
        ext_in_valid = 1'b1;
        ext_in_data = 8'hAA; step();
        chk("t6_dis_int0", interrupt, 0);
        ext_in_data = 8'hBB; step();
        ext_in_valid = 1'b0;
        chk("t6_dis_int1", interrupt, 0);
        step();
        chk("t6_dis_int2", interrupt, 0);
        chk("t6_count2", fifo_count, 2);
        int_en = 1'b1;
        step();
        chk("t6_en_pulse", interrupt, 1);
        step();
        chk("t6_en_pulse_end", interrupt, 0);
        ext_in_data = 8'hCC; ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        step();
        chk("t6_wait_no_pulse", interrupt, 0);
        chk("t6_count3", fifo_count, 3);
        cpu_rd = 1'b1;
        step(); step(); step();
        cpu_rd = 1'b0;
        chk("t6_drained", fifo_count, 0);
        ext_in_data = 8'hDD; ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        chk("t6_refill_int0", interrupt, 0);
        step();
        chk("t6_second_pulse", interrupt, 1);
        step();
        chk("t6_second_end", interrupt, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("t6_rst_int", interrupt, 0);
        chk("t6_rst_count", fifo_count, 0);
        chk("t6_rst_data_in", data_in, 8'h00);
        step();
        chk("t6_armed_idle", interrupt, 0);
        ext_in_data = 8'hEE; ext_in_valid = 1'b1;
        step();
        ext_in_valid = 1'b0;
        step();
        chk("t6_armed_pulse", interrupt, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
